prog_loader: RTL and testbench
==============================

# prog_loader

Writer side of the CPU program memory. The CPU only reads program memory; `prog_loader` fills a writable program store from an external byte stream. It assembles 16-bit instruction words from byte pairs, writes them to consecutive addresses from 0, and holds the CPU in reset for the whole load.

## Interface

Parameters:
- `p_size`, 4: program address width; the loader writes 2**p_size words.
- `i_size`, 16: instruction width; fixed at 16 (two bytes per word). Any other value is an elaboration error.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `load_req` in 1: start a load; sampled only in IDLE.
- `byte_in` in 8: incoming byte.
- `byte_valid` in 1: `byte_in` valid.
- `byte_ready` out 1: loader accepts a byte this cycle.
- `wr_en` out 1: program memory write strobe, one cycle per word.
- `wr_addr` out p_size: program memory write address.
- `wr_data` out i_size: instruction word to write.
- `cpu_hold` out 1: high while loading; the top level ORs it into the CPU reset.
- `done` out 1: one-cycle pulse when the last word is written.

## Operation

- States: IDLE, HI, LO, WRITE, DONE.
- IDLE:
  - `load_req`=1 → HI, `addr_cnt`←0, `cpu_hold`←1.
  - `byte_valid` is ignored; `byte_ready`=0.
- HI: `byte_ready`=1. A transfer (`byte_valid`&&`byte_ready`) latches `byte_in` into `wr_data[15:8]` → LO. With no transfer, the state holds.
- LO: `byte_ready`=1. A transfer latches `wr_data[7:0]` → WRITE.
- WRITE: `byte_ready`=0, `wr_en`=1, `wr_addr`=`addr_cnt`.
  - If `addr_cnt` == 2**p_size−1 → DONE.
  - Otherwise `addr_cnt`+1 → HI.
- DONE: `done`=1 for this one cycle, `cpu_hold`=0 from the next cycle, → IDLE.
- Byte order is big-endian: opcode byte first.
- `load_req` outside IDLE is ignored. A new load is accepted again the cycle after DONE.
- `addr_cnt` is p_size bits wide. It never wraps during a load, because exit happens on the last address.
- Reset mid-load: next edge → IDLE, all outputs at reset values. Words already written stay in memory, and `cpu_hold` drops at once.

## Timing

- Reset values: `byte_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `cpu_hold`=0, `done`=0, state IDLE.
- All outputs are registered or decoded from registered state only. There is no combinational path from `byte_valid` or `byte_in` to any output.
- `byte_ready` is a function of state only.
- `cpu_hold` rises the cycle after `load_req` is sampled in IDLE. It stays high through DONE.
- Minimum of 3 cycles per word (HI, LO, WRITE) with `byte_valid` held high. A full load of 16 words takes 1 + 48 + 1 cycles from `load_req` to the `done` pulse.
- `wr_data` and `wr_addr` are stable during the `wr_en` cycle. The memory captures them on that edge.
- `wr_data` holds its last value outside WRITE; consumers qualify it with `wr_en`.

## Structure

- Shared package `loader_pkg`:
  - State enum typedef `loader_state_t`.
  - Constant `BYTES_PER_INSTR`=2.
- Single module, no sub-module.
- The writable program store is a separate block, outside this spec. It takes `wr_en`, `wr_addr` and `wr_data` from the loader and serves CPU reads.

## Test plan

- Reset then idle: `reset`=1 for 2 cycles, then `byte_valid`=1 with no `load_req` → `byte_ready`=0, `wr_en`=0, `cpu_hold`=0.
- Full load: pulse `load_req`, then stream bytes 0x00..0x1F continuously → 16 `wr_en` pulses with `wr_addr` 0..15 and `wr_data` 0x0001, 0x0203, …, 0x1E1F. `done` pulses at cycle 50, then `cpu_hold` falls.
- Stalled stream: insert 3 idle cycles between each `byte_valid` → same writes. No `wr_en` until both bytes of each word arrive, and `byte_ready` stays 1 in HI and LO.
- Late `load_req`: pulse `load_req` again at word 5 → ignored, with no address restart (`wr_addr` continues 5,6,…).
- Reset mid-load: assert `reset` after the high byte of word 7 → next cycle IDLE with all outputs 0. A new load then restarts at `wr_addr`=0.
- Back-to-back loads: `load_req` the cycle after `done` → accepted, and the second load completes with `wr_addr` 0..15.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the program-memory loader.
package loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_HI    = 3'd1,
      S_LO    = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4
   } loader_state_t;

   localparam int BYTES_PER_INSTR = 2;

endpackage

// File: rtl/prog_loader.sv
// Fills the writable program store from a byte stream: big-endian byte pairs
// become 16-bit words written to addresses 0..2**p_size-1 while the CPU is held.
module prog_loader
   import loader_pkg::*;
#(
   parameter int p_size = 4,
   parameter int i_size = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_req,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic              wr_en,
   output logic [p_size-1:0] wr_addr,
   output logic [i_size-1:0] wr_data,
   output logic              cpu_hold,
   output logic              done,
   output logic [2:0]        o_dbg_state
);

   if (i_size != 8 * BYTES_PER_INSTR) begin : g_bad_i_size
      $error("prog_loader: i_size must be 16 (two bytes per instruction)");
   end

   // Handshake: a byte moves on a rising edge where byte_valid && byte_ready;
   // byte_ready depends on state only, so the producer never sees a comb loop.

   loader_state_t     r_state;
   loader_state_t     w_next_state;
   logic [p_size-1:0] r_addr_cnt;
   logic [i_size-1:0] r_wr_data;
   logic              w_hi_xfer;
   logic              w_lo_xfer;
   logic              w_last;

   assign w_hi_xfer = (r_state == S_HI) && byte_valid;
   assign w_lo_xfer = (r_state == S_LO) && byte_valid;
   assign w_last    = &r_addr_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_addr_cnt <= '0;
         r_wr_data  <= '0;
      end else begin
         if ((r_state == S_IDLE) && load_req) begin
            r_addr_cnt <= '0;
         end
         if (w_hi_xfer) begin
            r_wr_data[i_size-1 -: 8] <= byte_in;
         end
         if (w_lo_xfer) begin
            r_wr_data[7:0] <= byte_in;
         end
         // The last address exits to DONE, so the counter never wraps.
         if ((r_state == S_WRITE) && !w_last) begin
            r_addr_cnt <= r_addr_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      w_next_state = r_state;
      byte_ready   = 1'b0;
      wr_en        = 1'b0;
      done         = 1'b0;
      cpu_hold     = 1'b1;
      case (r_state)
         S_IDLE: begin
            cpu_hold = 1'b0;
            if (load_req) begin
               w_next_state = S_HI;
            end
         end
         S_HI: begin
            byte_ready = 1'b1;
            if (byte_valid) begin
               w_next_state = S_LO;
            end
         end
         S_LO: begin
            byte_ready = 1'b1;
            if (byte_valid) begin
               w_next_state = S_WRITE;
            end
         end
         S_WRITE: begin
            wr_en        = 1'b1;
            w_next_state = w_last ? S_DONE : S_HI;
         end
         S_DONE: begin
            done         = 1'b1;
            w_next_state = S_IDLE;
         end
         default: begin
            cpu_hold     = 1'b0;
            w_next_state = S_IDLE;
         end
      endcase
   end

   assign wr_addr     = r_addr_cnt;
   assign wr_data     = r_wr_data;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: full, stalled, late-request, aborted and
// back-to-back loads, with a write scoreboard fed by an expected queue.
module tb_prog_loader;
   import loader_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        load_req = 1'b0;
   logic [7:0]  byte_in = 8'h00;
   logic        byte_valid = 1'b0;
   logic        byte_ready;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [15:0] wr_data;
   logic        cpu_hold;
   logic        done;
   logic [2:0]  dbg_state;

   int          n_checks = 0;
   int          n_fail = 0;
   int          n_wr = 0;
   int          cyc = 0;
   int          load_cyc = 0;
   logic [19:0] exp_q[$];

   prog_loader #(.p_size(4), .i_size(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .load_req   (load_req),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .o_dbg_state(dbg_state)
   );

   // clock / reset block
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // scoreboard: every write strobe must match the oldest expected word
   always @(negedge clk) begin
      if (wr_en) begin
         n_wr++;
         check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            check("wr_addr_data", 32'({wr_addr, wr_data}), 32'(exp_q.pop_front()));
         end
         check("hold_in_write", 32'(cpu_hold), 32'd1);
      end
   end

   // driver tasks
   task automatic start_load();
      @(posedge clk); #1;
      check("hold_idle", 32'(cpu_hold), 32'd0);
      load_req = 1'b1;
      @(posedge clk); #1;
      load_req = 1'b0;
      load_cyc = cyc;
      check("hold_rise", 32'(cpu_hold), 32'd1);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      bit ok;
      byte_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
         @(negedge clk);
         if (g == gap - 1) begin
            check("stall_ready", 32'(byte_ready), 32'd1);
            check("stall_no_wr", 32'(wr_en), 32'd0);
         end
         @(posedge clk); #1;
      end
      byte_valid = 1'b1;
      byte_in    = b;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (byte_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         check("byte_ready_timeout", 32'd0, 32'd1);
      end else begin
         @(posedge clk); #1;
      end
   endtask

   task automatic wait_done(input bit check_timing);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      check("done_seen", 32'(seen), 32'd1);
      check("hold_thru_done", 32'(cpu_hold), 32'd1);
      // load_req cycle counts as cycle 1, the first HI cycle as cycle 2
      if (seen && check_timing) begin
         check("done_cycle", 32'(cyc - load_cyc + 2), 32'd50);
      end
   endtask

   task automatic run_load(input int gap, input int late_word, input int abort_word);
      int wr_start;
      logic [7:0] hi, lo;
      start_load();
      wr_start = n_wr;
      for (int k = 0; k < 16; k++) begin
         hi = 8'(2 * k);
         lo = 8'(2 * k + 1);
         if (k == late_word) load_req = 1'b1;
         send_byte(hi, gap);
         load_req = 1'b0;
         if (k == abort_word) begin
            byte_valid = 1'b0;
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            @(negedge clk);
            check("abort_state", 32'(dbg_state), 32'(S_IDLE));
            check("abort_ready", 32'(byte_ready), 32'd0);
            check("abort_wr_en", 32'(wr_en), 32'd0);
            check("abort_wr_addr", 32'(wr_addr), 32'd0);
            check("abort_wr_data", 32'(wr_data), 32'd0);
            check("abort_hold", 32'(cpu_hold), 32'd0);
            check("abort_done", 32'(done), 32'd0);
            check("abort_writes", 32'(n_wr - wr_start), 32'(abort_word));
            check("abort_drained", 32'(exp_q.size()), 32'd0);
            return;
         end
         send_byte(lo, gap);
         exp_q.push_back({4'(k), hi, lo});
      end
      byte_valid = 1'b0;
      wait_done(gap == 0);
      check("writes_drained", 32'(exp_q.size()), 32'd0);
      check("write_count", 32'(n_wr - wr_start), 32'd16);
   endtask

   initial begin
      // reset, then an unrequested byte stream must be ignored
      reset = 1'b1;
      byte_valid = 1'b1;
      byte_in = 8'hA5;
      repeat (2) @(posedge clk);
      #1;
      check("rst_state", 32'(dbg_state), 32'(S_IDLE));
      check("rst_wr_addr", 32'(wr_addr), 32'd0);
      check("rst_wr_data", 32'(wr_data), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("idle_ready", 32'(byte_ready), 32'd0);
      check("idle_wr_en", 32'(wr_en), 32'd0);
      check("idle_hold", 32'(cpu_hold), 32'd0);
      check("idle_wr_data", 32'(wr_data), 32'd0);
      byte_valid = 1'b0;

      run_load(0, -1, -1);   // full continuous load with latency check
      run_load(3, -1, -1);   // stalled stream
      run_load(0, 5, -1);    // late load_req ignored
      run_load(0, -1, 7);    // reset after high byte of word 7
      run_load(0, -1, -1);   // restart from address 0
      run_load(0, -1, -1);   // back-to-back with the previous load

      repeat (2) @(posedge clk);
      #1;
      check("final_hold", 32'(cpu_hold), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
